// File: rtl/iic_arbiter.sv
// iic_arbiter: shares one iic_controller register-access port between two requesters.
// m0 is the HMC5883L sequencing controller and m1 is the second sensor controller.
// Each grant covers exactly one register read or write. Grants alternate between the
// two requesters when both are pending. A watchdog aborts any transaction that
// iic_controller never acknowledges and reports it with err.
//
// Ports:
//   clk, rst_n                    system clock, asynchronous active-low reset
//   mX_iicwr_req / mX_iicrd_req   requester write/read request (level, held until ack)
//   mX_iic_addr / mX_iic_wrdb     requester register address / write data
//   mX_iic_rddb                   read data back to requester (valid with ack)
//   mX_iic_ack / mX_iic_err       one-cycle completion pulse / timed-out flag
//   iicwr_req / iicrd_req         request to iic_controller
//   iic_addr / iic_wrdb           latched address / write data to iic_controller
//   iic_rddb / iic_ack            read data / done pulse from iic_controller
//   busy                          transaction in flight (BUSY or GAP)
module iic_arbiter #(
    parameter int unsigned TIMEOUT = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_iicwr_req,
    input  logic       m0_iicrd_req,
    input  logic [7:0] m0_iic_addr,
    input  logic [7:0] m0_iic_wrdb,
    output logic [7:0] m0_iic_rddb,
    output logic       m0_iic_ack,
    output logic       m0_iic_err,
    input  logic       m1_iicwr_req,
    input  logic       m1_iicrd_req,
    input  logic [7:0] m1_iic_addr,
    input  logic [7:0] m1_iic_wrdb,
    output logic [7:0] m1_iic_rddb,
    output logic       m1_iic_ack,
    output logic       m1_iic_err,
    output logic       iicwr_req,
    output logic       iicrd_req,
    output logic [7:0] iic_addr,
    output logic [7:0] iic_wrdb,
    input  logic [7:0] iic_rddb,
    input  logic       iic_ack,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    // Last BUSY cycle index before the watchdog fires.
    localparam logic [23:0] TimeoutLast = 24'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rw_q, rw_d;            // 1 = write
    logic        last_q, last_d;        // requester granted most recently
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wrdb_q, wrdb_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  rddb0_q, rddb0_d;
    logic [7:0]  rddb1_q, rddb1_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic        wr_req_q, wr_req_d;
    logic        rd_req_q, rd_req_d;
    logic        busy_q, busy_d;

    logic pend0, pend1, grant;

    assign pend0 = m0_iicwr_req | m0_iicrd_req;
    assign pend1 = m1_iicwr_req | m1_iicrd_req;
    // On a tie the requester that did not go last wins; otherwise whoever is pending.
    assign grant = (pend0 && pend1) ? ~last_q : pend1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rw_d     = rw_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wrdb_d   = wrdb_q;
        cnt_d    = cnt_q;
        rddb0_d  = rddb0_q;
        rddb1_d  = rddb1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        busy_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pend0 || pend1) begin
                    owner_d  = grant;
                    last_d   = grant;
                    // Write wins when a requester raises both wr and rd.
                    rw_d     = grant ? m1_iicwr_req : m0_iicwr_req;
                    addr_d   = grant ? m1_iic_addr : m0_iic_addr;
                    wrdb_d   = grant ? m1_iic_wrdb : m0_iic_wrdb;
                    cnt_d    = 24'd0;
                    wr_req_d = rw_d;
                    rd_req_d = ~rw_d;
                    busy_d   = 1'b1;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                busy_d   = 1'b1;
                wr_req_d = rw_q;
                rd_req_d = ~rw_q;
                cnt_d    = cnt_q + 24'd1;
                if (iic_ack) begin
                    // Ack beats a watchdog expiry in the same cycle.
                    if (!rw_q) begin
                        if (owner_q) rddb1_d = iic_rddb;
                        else         rddb0_d = iic_rddb;
                    end
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    ack0_d   = ~owner_q;
                    ack1_d   = owner_q;
                    state_d  = StGap;
                end else if (cnt_q == TimeoutLast) begin
                    if (owner_q) rddb1_d = 8'h00;
                    else         rddb0_d = 8'h00;
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    ack0_d   = ~owner_q;
                    ack1_d   = owner_q;
                    err0_d   = ~owner_q;
                    err1_d   = owner_q;
                    state_d  = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            rw_q     <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= 8'h00;
            wrdb_q   <= 8'h00;
            cnt_q    <= 24'd0;
            rddb0_q  <= 8'h00;
            rddb1_q  <= 8'h00;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rw_q     <= rw_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wrdb_q   <= wrdb_d;
            cnt_q    <= cnt_d;
            rddb0_q  <= rddb0_d;
            rddb1_q  <= rddb1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            busy_q   <= busy_d;
        end
    end

    assign m0_iic_rddb = rddb0_q;
    assign m0_iic_ack  = ack0_q;
    assign m0_iic_err  = err0_q;
    assign m1_iic_rddb = rddb1_q;
    assign m1_iic_ack  = ack1_q;
    assign m1_iic_err  = err1_q;
    assign iicwr_req   = wr_req_q;
    assign iicrd_req   = rd_req_q;
    assign iic_addr    = addr_q;
    assign iic_wrdb    = wrdb_q;
    assign busy        = busy_q;

endmodule
